// File: rtl/mac_sequencer_pkg.sv
// Shared types and default sizing for the MAC job sequencer.
package mac_sequencer_pkg;

    localparam int unsigned DefSteps = 8;
    localparam int unsigned DefCntW  = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Command/datapath-control bundle between the MAC top level and the sequencer.
interface mac_sequencer_if
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
);

    logic             start_i;
    logic             stall_i;
    logic             abort_i;
    logic             done_ack_i;
    logic             ready_o;
    logic             acc_clear_o;
    logic             acc_en_o;
    logic [CNT_W-1:0] step_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, stall_i, abort_i, done_ack_i,
        output ready_o, acc_clear_o, acc_en_o, step_o, busy_o, done_o
    );

    modport master (
        output start_i, stall_i, abort_i, done_ack_i,
        input  ready_o, acc_clear_o, acc_en_o, step_o, busy_o, done_o
    );

endinterface

// File: rtl/mac_step_counter.sv
// Operand index counter: counts 0..STEPS-1 and returns to 0 after the last step.
module mac_step_counter
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned STEPS = DefSteps,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;

    assign last_o  = (count_q == CNT_W'(STEPS - 1));
    assign count_o = count_q;

    // Wrapping at the last step keeps codes >= STEPS unreachable.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= last_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM for one multiply-accumulate job: clear, STEPS accumulate steps, then done.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned STEPS = DefSteps,
    parameter int unsigned CNT_W = DefCntW
) (
    input logic            clk_i,
    input logic            reset_i,
    mac_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic             ready_q, clear_q, busy_q, done_q;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             cnt_clear, cnt_en;

    always_comb begin
        state_d = state_q;
        if (bus.abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start_i) state_d = StClear;
                StClear: state_d = StRun;
                StRun:   if (!bus.stall_i && last) state_d = StDone;
                StDone:  if (bus.done_ack_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Flags are registered from the next state so outputs carry no input paths.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == StIdle);
            clear_q <= (state_d == StClear);
            busy_q  <= (state_d == StClear) || (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign cnt_clear = (state_q != StRun) || bus.abort_i;
    assign cnt_en    = (state_q == StRun) && !bus.stall_i;

    mac_step_counter #(
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .count_o (count),
        .last_o  (last)
    );

    assign bus.ready_o     = ready_q;
    assign bus.acc_clear_o = clear_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.step_o      = count;
    assign bus.acc_en_o    = (state_q == StRun) && !bus.stall_i;

endmodule
